// File: rtl/spi_accel_pkg.sv
// Shared definitions for the accelerometer SPI link:
// packet layout, register map and arbiter state encoding.
package spi_accel_pkg;

   localparam int PKT_W   = 16;
   localparam int RW_BIT  = 15;
   localparam int MB_BIT  = 14;
   localparam int ADDR_HI = 13;
   localparam int ADDR_LO = 8;
   localparam int DATA_HI = 7;
   localparam int DATA_LO = 0;

   localparam logic RW_WRITE  = 1'b0;
   localparam logic RW_READ   = 1'b1;
   localparam logic MB_SINGLE = 1'b0;
   localparam logic MB_MULTI  = 1'b1;

   localparam logic [5:0] REG_DEVID       = 6'h00;
   localparam logic [5:0] REG_BW_RATE     = 6'h2C;
   localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
   localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
   localparam logic [5:0] REG_DATAX1      = 6'h33;
   localparam logic [5:0] REG_DATAY1      = 6'h35;

   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
   localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
   localparam logic [1:0] ST_DONE_ENC  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_ISSUE = ST_ISSUE_ENC,
      ST_WAIT  = ST_WAIT_ENC,
      ST_DONE  = ST_DONE_ENC
   } arb_state_e;

   function automatic logic [PKT_W-1:0] mk_pkt(
      input logic       rw,
      input logic       mb,
      input logic [5:0] addr,
      input logic [7:0] data
   );
      logic [PKT_W-1:0] p;
      p                  = '0;
      p[RW_BIT]          = rw;
      p[MB_BIT]          = mb;
      p[ADDR_HI:ADDR_LO] = addr;
      p[DATA_HI:DATA_LO] = data;
      return p;
   endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: first set request at or
// after the pointer, wrapping, as one-hot, index and valid.
module spi_rr_picker #(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   int d;
   int best_d;

   // Lowest wrap distance from the pointer wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = |req_i;
      d       = 0;
      best_d  = N;
      for (int k = 0; k < N; k++) begin
         d = k - int'(ptr_i);
         if (d < 0) d = d + N;
         if (req_i[k] && (d < best_d)) begin
            best_d = d;
            idx_o  = IW'(k);
         end
      end
      for (int k = 0; k < N; k++) begin
         gnt_o[k] = valid_o && (idx_o == IW'(k));
      end
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin owner arbitration of the shared accelerometer SPI
// master, with per-transaction watchdog abort.
module spi_txn_arbiter
   import spi_accel_pkg::*;
#(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [PKT_W*NUM_REQ-1:0] pachet_i,
   output logic [NUM_REQ-1:0]       ack_o,
   output logic [7:0]               rdata_o,
   output logic                     err_o,
   output logic                     m_req_o,
   output logic [PKT_W-1:0]         m_pachet_o,
   input  logic                     m_ack_i,
   input  logic [7:0]               m_pachet_returnat_i,
   output logic [NUM_REQ-1:0]       grant_o,
   output logic                     busy_o,
   output logic                     timeout_sticky_o
);

   localparam int          IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [PKT_W-1:0]   pkt_q, pkt_d;
   logic               mreq_q, mreq_d;
   logic [IW-1:0]      rr_q, rr_d;
   logic [15:0]        wd_q, wd_d;
   logic               err_q, err_d;
   logic [7:0]         rdata_q, rdata_d;
   logic               sticky_q, sticky_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_vld;
   logic [PKT_W-1:0]   pick_pkt;
   logic               wd_hit;

   spi_rr_picker #(
      .N (NUM_REQ)
   ) u_picker (
      .req_i   (req_i),
      .ptr_i   (rr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_vld)
   );

   always_comb begin
      pick_pkt = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_gnt[k]) begin
            pick_pkt = pick_pkt | pachet_i[PKT_W*k +: PKT_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ack_d    = '0;
      pkt_d    = pkt_q;
      mreq_d   = mreq_q;
      rr_d     = rr_q;
      wd_d     = wd_q;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      sticky_d = sticky_q;
      wd_hit   = WD_EN && (wd_q == WD_LAST);
      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               grant_d = pick_gnt;
               pkt_d   = pick_pkt;
               rr_d    = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mreq_d  = 1'b1;
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wd_d = wd_q + 16'd1;
            // A real ack always beats a coincident watchdog expiry.
            if (m_ack_i || wd_hit) begin
               ack_d    = grant_q;
               mreq_d   = 1'b0;
               pkt_d    = '0;
               rdata_d  = m_ack_i ? m_pachet_returnat_i : 8'h00;
               err_d    = !m_ack_i;
               sticky_d = sticky_q | !m_ack_i;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         ack_q    <= '0;
         pkt_q    <= '0;
         mreq_q   <= 1'b0;
         rr_q     <= '0;
         wd_q     <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         pkt_q    <= pkt_d;
         mreq_q   <= mreq_d;
         rr_q     <= rr_d;
         wd_q     <= wd_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         sticky_q <= sticky_d;
      end
   end

   assign ack_o            = ack_q;
   assign rdata_o          = rdata_q;
   assign err_o            = err_q;
   assign m_req_o          = mreq_q;
   assign m_pachet_o       = pkt_q;
   assign grant_o          = grant_q;
   assign busy_o           = (state_q != ST_IDLE);
   assign timeout_sticky_o = sticky_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: transaction-timeline reference model
// compared every cycle, directed scenarios plus random traffic.
module tb_spi_txn_arbiter;
   import spi_accel_pkg::*;

   localparam int N  = 3;
   localparam int TO = 8;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic [N-1:0]  req_i;
   logic [16*N-1:0] pachet_i;
   logic [N-1:0]  ack_o;
   logic [7:0]    rdata_o;
   logic          err_o;
   logic          m_req_o;
   logic [15:0]   m_pachet_o;
   logic          m_ack_i;
   logic [7:0]    m_pachet_returnat_i;
   logic [N-1:0]  grant_o;
   logic          busy_o;
   logic          timeout_sticky_o;

   always #5 clk_i = ~clk_i;

   spi_txn_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i               (clk_i),
      .rst_n_i             (rst_n_i),
      .req_i               (req_i),
      .pachet_i            (pachet_i),
      .ack_o               (ack_o),
      .rdata_o             (rdata_o),
      .err_o               (err_o),
      .m_req_o             (m_req_o),
      .m_pachet_o          (m_pachet_o),
      .m_ack_i             (m_ack_i),
      .m_pachet_returnat_i (m_pachet_returnat_i),
      .grant_o             (grant_o),
      .busy_o              (busy_o),
      .timeout_sticky_o    (timeout_sticky_o)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: one transaction record timed by edge count.
   int          cyc;
   int          m_owner;
   int          m_rr;
   int          m_tg;
   bit          m_active;
   bit          m_done;
   bit          m_err;
   bit          m_sticky;
   logic [7:0]  m_rdata;
   logic [15:0] m_pkt;

   bit chk_en   = 1'b0;
   bit auto_req = 1'b0;
   bit auto_mst = 1'b0;
   int mst_max  = 4;
   int mdly     = -1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      cyc      = 0;
      m_owner  = 0;
      m_rr     = 0;
      m_tg     = 0;
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_sticky = 1'b0;
      m_rdata  = 8'h00;
      m_pkt    = 16'h0;
   endfunction

   task automatic model_step();
      bit found;
      cyc++;
      if (!m_active) begin
         if (req_i != '0) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (!found && req_i[(m_rr + i) % N]) begin
                  m_owner = (m_rr + i) % N;
                  found   = 1'b1;
               end
            end
            m_rr     = (m_owner + 1) % N;
            m_pkt    = pachet_i[16*m_owner +: 16];
            m_tg     = cyc;
            m_active = 1'b1;
            m_done   = 1'b0;
            m_err    = 1'b0;
         end
      end else if (!m_done) begin
         if (cyc >= m_tg + 2) begin
            if (m_ack_i) begin
               m_done  = 1'b1;
               m_rdata = m_pachet_returnat_i;
            end else if (cyc == m_tg + 1 + TO) begin
               m_done   = 1'b1;
               m_rdata  = 8'h00;
               m_err    = 1'b1;
               m_sticky = 1'b1;
            end
         end
      end else begin
         m_active = 1'b0;
         m_done   = 1'b0;
      end
   endtask

   task automatic compare();
      logic [N-1:0] oh;
      oh = m_active ? N'(1 << m_owner) : '0;
      check("grant", 32'(grant_o), 32'(oh));
      check("busy", 32'(busy_o), 32'(m_active));
      check("m_req", 32'(m_req_o),
            32'(m_active && !m_done && (cyc >= m_tg + 1)));
      check("m_pachet", 32'(m_pachet_o),
            32'((m_active && !m_done) ? m_pkt : 16'h0));
      check("ack", 32'(ack_o), 32'((m_active && m_done) ? oh : '0));
      check("err", 32'(err_o), 32'(m_active && m_done && m_err));
      check("rdata", 32'(rdata_o), 32'(m_rdata));
      check("sticky", 32'(timeout_sticky_o), 32'(m_sticky));
   endtask

   function automatic logic [15:0] rand_pkt();
      logic [5:0] regs [6];
      regs = '{REG_DEVID, REG_BW_RATE, REG_POWER_CTL,
               REG_DATA_FORMAT, REG_DATAX1, REG_DATAY1};
      return mk_pkt($urandom_range(0, 1) != 0 ? RW_READ : RW_WRITE,
                    $urandom_range(0, 1) != 0 ? MB_MULTI : MB_SINGLE,
                    regs[$urandom_range(0, 5)], 8'($urandom));
   endfunction

   task automatic drive_req();
      for (int k = 0; k < N; k++) begin
         if (req_i[k]) begin
            if (ack_o[k]) req_i[k] = ($urandom_range(0, 3) == 0);
         end else if ($urandom_range(0, 3) == 0) begin
            req_i[k] = 1'b1;
            pachet_i[16*k +: 16] = rand_pkt();
         end else if ($urandom_range(0, 1) == 0) begin
            pachet_i[16*k +: 16] = rand_pkt();
         end
      end
   endtask

   task automatic drive_mst();
      m_ack_i = 1'b0;
      if (m_req_o) begin
         if (mdly < 0) mdly = $urandom_range(0, mst_max);
         if (mdly == 0) begin
            m_ack_i = 1'b1;
            m_pachet_returnat_i = 8'($urandom);
            mdly = -1;
         end else begin
            mdly--;
         end
      end else begin
         mdly = -1;
         if ($urandom_range(0, 15) == 0) begin
            m_ack_i = 1'b1;
            m_pachet_returnat_i = 8'($urandom);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (rst_n_i) model_step();
      #1;
      if (chk_en && rst_n_i) compare();
      @(negedge clk_i);
      if (auto_req) drive_req();
      if (auto_mst) drive_mst();
   endtask

   task automatic wait_mreq();
      int i;
      i = 0;
      while (!m_req_o && i < 20) begin
         tick();
         i++;
      end
      check("m_req_rise", 32'(m_req_o), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int order [6];
      int exp_ord [6];
      int nacks;
      int cnt;
      exp_ord = '{0, 1, 2, 0, 1, 2};
      order   = '{-1, -1, -1, -1, -1, -1};
      rst_n_i = 1'b0;
      req_i = '0;
      pachet_i = '0;
      m_ack_i = 1'b0;
      m_pachet_returnat_i = 8'h00;
      model_reset();
      tick();
      tick();
      check("rst_grant", 32'(grant_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_m_req", 32'(m_req_o), 32'd0);
      check("rst_outs", 32'({ack_o, err_o, rdata_o, timeout_sticky_o}), 32'd0);
      check("rst_m_pachet", 32'(m_pachet_o), 32'd0);
      rst_n_i = 1'b1;
      chk_en  = 1'b1;

      // single request
      pachet_i[15:0] = mk_pkt(RW_WRITE, MB_SINGLE, REG_DATA_FORMAT, 8'h0C);
      req_i = 3'b001;
      wait_mreq();
      check("t1_pkt", 32'(m_pachet_o), 32'h310C);
      repeat (4) tick();
      m_ack_i = 1'b1;
      m_pachet_returnat_i = 8'hAB;
      tick();
      check("t1_ack", 32'(ack_o), 32'b001);
      check("t1_rdata", 32'(rdata_o), 32'hAB);
      check("t1_err", 32'(err_o), 32'd0);
      m_ack_i = 1'b0;
      req_i = '0;
      tick();
      check("t1_ack_drop", 32'(ack_o), 32'd0);
      check("t1_pkt_clr", 32'(m_pachet_o), 32'd0);

      // asynchronous reset in the middle of WAIT
      pachet_i[31:16] = mk_pkt(RW_READ, MB_SINGLE, REG_DEVID, 8'h00);
      req_i = 3'b010;
      wait_mreq();
      tick();
      tick();
      #2 rst_n_i = 1'b0;
      #1;
      check("arst_m_req", 32'(m_req_o), 32'd0);
      check("arst_grant", 32'(grant_o), 32'd0);
      check("arst_ack", 32'(ack_o), 32'd0);
      check("arst_busy", 32'(busy_o), 32'd0);
      model_reset();
      req_i = '0;
      tick();
      tick();
      rst_n_i = 1'b1;
      m_ack_i = 1'b1;
      m_pachet_returnat_i = 8'hEE;
      tick();
      m_ack_i = 1'b0;
      tick();
      check("stray_ack", 32'(ack_o), 32'd0);
      check("stray_rdata", 32'(rdata_o), 32'd0);

      // all three requesting, each re-raising right after its ack
      pachet_i[15:0]  = mk_pkt(RW_READ, MB_MULTI, REG_DATAX1, 8'h00);
      pachet_i[31:16] = mk_pkt(RW_READ, MB_MULTI, REG_DATAY1, 8'h00);
      pachet_i[47:32] = mk_pkt(RW_READ, MB_SINGLE, REG_DEVID, 8'h00);
      req_i = 3'b111;
      auto_mst = 1'b1;
      mst_max = 4;
      nacks = 0;
      for (int c = 0; c < 200 && nacks < 6; c++) begin
         tick();
         if (ack_o != '0) begin
            for (int k = 0; k < N; k++) if (ack_o[k]) order[nacks] = k;
            nacks++;
            req_i = (nacks == 6) ? 3'b000 : (req_i & ~ack_o);
         end else begin
            req_i = 3'b111;
         end
      end
      auto_mst = 1'b0;
      m_ack_i = 1'b0;
      mdly = -1;
      for (int i = 0; i < 6; i++) check("rr_order", 32'(order[i]), 32'(exp_ord[i]));
      repeat (3) tick();

      // ack arriving on the final watchdog cycle
      pachet_i[15:0] = mk_pkt(RW_READ, MB_SINGLE, REG_BW_RATE, 8'h00);
      req_i = 3'b001;
      wait_mreq();
      repeat (7) tick();
      m_ack_i = 1'b1;
      m_pachet_returnat_i = 8'h5A;
      tick();
      check("race_ack", 32'(ack_o), 32'b001);
      check("race_err", 32'(err_o), 32'd0);
      check("race_rdata", 32'(rdata_o), 32'h5A);
      check("race_sticky", 32'(timeout_sticky_o), 32'd0);
      m_ack_i = 1'b0;
      req_i = '0;
      tick();

      // packet held by the arbiter while the requester changes it
      pachet_i[31:16] = mk_pkt(RW_READ, MB_MULTI, REG_DATAX1, 8'h00);
      req_i = 3'b010;
      wait_mreq();
      tick();
      tick();
      pachet_i[31:16] = 16'h1234;
      tick();
      tick();
      check("iso_hold", 32'(m_pachet_o), 32'hF300);
      m_ack_i = 1'b1;
      m_pachet_returnat_i = 8'h77;
      tick();
      check("iso_clr", 32'(m_pachet_o), 32'd0);
      check("iso_ack", 32'(ack_o), 32'b010);
      check("iso_rdata", 32'(rdata_o), 32'h77);
      m_ack_i = 1'b0;
      req_i = '0;
      tick();

      // master never answers
      pachet_i[47:32] = mk_pkt(RW_WRITE, MB_SINGLE, REG_POWER_CTL, 8'h08);
      req_i = 3'b100;
      wait_mreq();
      cnt = 0;
      while (ack_o == '0 && cnt < 30) begin
         tick();
         cnt++;
      end
      check("to_latency", 32'(cnt), 32'd8);
      check("to_ack", 32'(ack_o), 32'b100);
      check("to_err", 32'(err_o), 32'd1);
      check("to_rdata", 32'(rdata_o), 32'd0);
      check("to_sticky", 32'(timeout_sticky_o), 32'd1);
      req_i = '0;
      tick();
      check("to_err_drop", 32'(err_o), 32'd0);
      pachet_i[15:0] = mk_pkt(RW_READ, MB_SINGLE, REG_DEVID, 8'h00);
      req_i = 3'b001;
      wait_mreq();
      tick();
      m_ack_i = 1'b1;
      m_pachet_returnat_i = 8'hE5;
      tick();
      check("post_to_ack", 32'(ack_o), 32'b001);
      check("post_to_err", 32'(err_o), 32'd0);
      check("post_to_rdata", 32'(rdata_o), 32'hE5);
      check("post_to_sticky", 32'(timeout_sticky_o), 32'd1);
      m_ack_i = 1'b0;
      req_i = '0;
      tick();

      // random traffic, timeouts and stray acks included
      auto_req = 1'b1;
      auto_mst = 1'b1;
      mst_max = 11;
      repeat (3000) tick();
      auto_req = 1'b0;
      auto_mst = 1'b0;
      req_i = '0;
      m_ack_i = 1'b0;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
